pwm_line_sequencer: RTL

Line-level controller for the PWM datapath: collects one duty byte per channel over a valid/ready stream into a shadow buffer, and on each hsync rising edge commits the shadow set to the PWM channels. It then clears the shared 8-bit global counter and enables the PWM blocks for exactly one 256-count period. It sits between the pixel/duty source and the `global_counter` + `PWMblock` array, replacing hand-driven hsync/rst sequencing.

---
 rtl/pwm_pkg.sv | 21 ++
 rtl/pwm_shadow_buf.sv | 83 ++++++++
 rtl/pwm_line_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pwm_pkg
// Brief   : Shared constants for the PWM line sequencer (widths, states, err bits).
// Revision: 1.0
// ============================================================================
package pwm_pkg;

    localparam int PWM_DATA_W = 8;
    localparam logic [PWM_DATA_W-1:0] PWM_CNT_MAX = 8'hFF;

    localparam int ERR_UNDERRUN = 0;
    localparam int ERR_OVERRUN  = 1;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_CLEAR = 2'd1;
    localparam state_t ST_RUN   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/pwm_shadow_buf.sv
`default_nettype none
// ============================================================================
// Module  : pwm_shadow_buf
// Brief   : Collects one duty byte per channel into a shadow set; commit empties it.
// Revision: 1.0
// ============================================================================
module pwm_shadow_buf
    import pwm_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int DATA_W   = PWM_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       commit,
    output logic                       in_ready,
    output logic                       shadow_full,
    output logic [CHANNELS*DATA_W-1:0] shadow
);

    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

    logic [IDX_W-1:0] widx_q, widx_d;
    logic             full_q, full_d;
    logic             accept;

    assign accept      = in_valid & ~full_q;
    assign in_ready    = ~full_q;
    assign shadow_full = full_q;

    // Commit only happens while full and accept only while not full, so they never collide.
    always_comb begin
        widx_d = widx_q;
        full_d = full_q;
        if (commit) begin
            full_d = 1'b0;
        end
        if (accept) begin
            if (widx_q == LAST_IDX) begin
                widx_d = '0;
                full_d = 1'b1;
            end else begin
                widx_d = widx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            widx_q <= '0;
            full_q <= 1'b0;
        end else begin
            widx_q <= widx_d;
            full_q <= full_d;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [DATA_W-1:0] byte_q, byte_d;

        always_comb begin
            byte_d = byte_q;
            if (accept && (widx_q == IDX_W'(k))) begin
                byte_d = in_data;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                byte_q <= '0;
            end else begin
                byte_q <= byte_d;
            end
        end

        assign shadow[k*DATA_W +: DATA_W] = byte_q;
    end

endmodule
`default_nettype wire

// File: rtl/pwm_line_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : pwm_line_sequencer
// Brief   : Commits shadow duty set on hsync rise, clears counter, runs one PWM period.
// Revision: 1.0
// ============================================================================
module pwm_line_sequencer
    import pwm_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int DATA_W   = PWM_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       hsync,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          count,
    output logic                       cnt_clr,
    output logic                       pwm_en,
    output logic [CHANNELS*DATA_W-1:0] duty,
    output logic                       line_done,
    output logic [1:0]                 err,
    input  logic                       err_clr
);

    state_t                      state_q, state_d;
    logic                        hsync_d_q;
    logic [CHANNELS*DATA_W-1:0]  duty_q, duty_d;
    logic                        cnt_clr_q, cnt_clr_d;
    logic                        pwm_en_q, pwm_en_d;
    logic                        line_done_q, line_done_d;
    logic [1:0]                  err_q, err_d, err_set;

    logic                        hs_rise;
    logic                        commit;
    logic                        shadow_full;
    logic [CHANNELS*DATA_W-1:0]  shadow;

    assign hs_rise = hsync & ~hsync_d_q;
    assign commit  = (state_q == ST_IDLE) && hs_rise && shadow_full;

    pwm_shadow_buf #(
        .CHANNELS (CHANNELS),
        .DATA_W   (DATA_W)
    ) u_shadow (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .commit      (commit),
        .in_ready    (in_ready),
        .shadow_full (shadow_full),
        .shadow      (shadow)
    );

    always_comb begin
        state_d     = state_q;
        duty_d      = duty_q;
        cnt_clr_d   = 1'b0;
        pwm_en_d    = 1'b0;
        line_done_d = 1'b0;
        err_set     = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (hs_rise) begin
                    if (shadow_full) begin
                        duty_d    = shadow;
                        cnt_clr_d = 1'b1;
                        state_d   = ST_CLEAR;
                    end else begin
                        err_set[ERR_UNDERRUN] = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                pwm_en_d = 1'b1;
                state_d  = ST_RUN;
                if (hs_rise) begin
                    err_set[ERR_OVERRUN] = 1'b1;
                end
            end
            ST_RUN: begin
                if (hs_rise) begin
                    err_set[ERR_OVERRUN] = 1'b1;
                end
                // Counter at terminal value closes the 256-count period.
                if (count == PWM_CNT_MAX) begin
                    line_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    pwm_en_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        err_d = (err_clr ? 2'b00 : err_q) | err_set;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            hsync_d_q   <= 1'b0;
            duty_q      <= '0;
            cnt_clr_q   <= 1'b0;
            pwm_en_q    <= 1'b0;
            line_done_q <= 1'b0;
            err_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            hsync_d_q   <= hsync;
            duty_q      <= duty_d;
            cnt_clr_q   <= cnt_clr_d;
            pwm_en_q    <= pwm_en_d;
            line_done_q <= line_done_d;
            err_q       <= err_d;
        end
    end

    assign duty      = duty_q;
    assign cnt_clr   = cnt_clr_q;
    assign pwm_en    = pwm_en_q;
    assign line_done = line_done_q;
    assign err       = err_q;

endmodule
`default_nettype wire
